// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring dividers.
// Helpers work on MaxW-bit values; callers extend operands and truncate results.
package div_pkg;

  localparam int unsigned MaxW = 64;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

  // Magnitude of a value already sign-extended to MaxW bits when sgn is set.
  function automatic logic [MaxW-1:0] abs_mag(input logic [MaxW-1:0] value, input logic sgn);
    return (sgn && value[MaxW-1]) ? -value : value;
  endfunction

  function automatic logic [MaxW-1:0] neg_if(input logic [MaxW-1:0] value, input logic cond);
    return cond ? -value : value;
  endfunction

endpackage

// File: rtl/seq_divider_p_ctrl.sv
// Divider controller: IDLE -> ITER -> FIX sequencing, iteration counter,
// registered ready/done and the load/step/fix strobes for the datapath.
module seq_divider_p_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_bzero,
  output logic o_ready,
  output logic o_done,
  output logic o_load,
  output logic o_step,
  output logic o_fix
);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;
  logic             r_done;

  assign o_load  = i_start && (r_state == IDLE);
  assign o_step  = (r_state == ITER);
  assign o_fix   = (r_state == FIX);
  assign o_ready = r_ready;
  assign o_done  = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_count <= CNT_W'(WIDTH);
            r_ready <= 1'b0;
            // A zero divisor skips the iterations entirely.
            r_state <= i_bzero ? FIX : ITER;
          end
        end
        ITER: begin
          r_count <= r_count - 1'b1;
          if (r_count == CNT_W'(1)) r_state <= FIX;
        end
        FIX: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seq_divider_p_dp.sv
// Divider datapath: magnitude loading, restoring shift-subtract on {P,A},
// sign fixup and result/flag registers. WIDTH must stay below 64.
module seq_divider_p_dp
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_fix,
  input  logic             i_sgn,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_bzero,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_dbz,
  output logic             o_ovf
);

  logic             r_sgn, r_sa, r_sb;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_a, r_b, r_araw;
  logic [WIDTH-1:0] r_q, r_r;
  logic             r_dbz, r_ovf;

  logic [MaxW-1:0]  w_a_ext, w_b_ext;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_shift, w_diff;
  logic [WIDTH-1:0] w_q_fix, w_r_fix;

  assign w_a_ext = {{(MaxW-WIDTH){i_sgn & i_a[WIDTH-1]}}, i_a};
  assign w_b_ext = {{(MaxW-WIDTH){i_sgn & i_b[WIDTH-1]}}, i_b};
  assign w_a_mag = WIDTH'(abs_mag(w_a_ext, i_sgn));
  assign w_b_mag = WIDTH'(abs_mag(w_b_ext, i_sgn));

  assign w_shift = {r_p[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  assign w_q_fix = WIDTH'(neg_if(MaxW'(r_a), r_sa ^ r_sb));
  assign w_r_fix = WIDTH'(neg_if(MaxW'(r_p), r_sa));

  assign o_bzero = (i_b == '0);
  assign o_q     = r_q;
  assign o_r     = r_r;
  assign o_dbz   = r_dbz;
  assign o_ovf   = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn  <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_p    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_araw <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_load) begin
        r_sgn  <= i_sgn;
        r_sa   <= i_sgn & i_a[WIDTH-1];
        r_sb   <= i_sgn & i_b[WIDTH-1];
        r_araw <= i_a;
        r_a    <= w_a_mag;
        r_b    <= w_b_mag;
        r_p    <= '0;
      end else if (i_step) begin
        r_p <= w_diff[WIDTH] ? w_shift : w_diff;
        r_a <= {r_a[WIDTH-2:0], ~w_diff[WIDTH]};
      end
      if (i_fix) begin
        if (r_b == '0) begin
          r_q   <= '1;
          r_r   <= r_araw;
          r_dbz <= 1'b1;
          r_ovf <= 1'b0;
        end else begin
          r_q   <= w_q_fix;
          r_r   <= w_r_fix;
          r_dbz <= 1'b0;
          // A non-negative signed quotient with its MSB set can only be MIN / -1.
          r_ovf <= r_sgn & ~(r_sa ^ r_sb) & r_a[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: rtl/seq_divider_p.sv
// Parametrised sequential restoring divider, one quotient bit per clock,
// signed/unsigned per operation, with divide-by-zero and overflow flags.
module seq_divider_p
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] Abus,
  input  logic [WIDTH-1:0] Bbus,
  output logic [WIDTH-1:0] Qbus,
  output logic [WIDTH-1:0] Rbus,
  output logic             ready,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic w_load, w_step, w_fix, w_bzero;

  seq_divider_p_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .i_start (start),
    .i_bzero (w_bzero),
    .o_ready (ready),
    .o_done  (done),
    .o_load  (w_load),
    .o_step  (w_step),
    .o_fix   (w_fix)
  );

  seq_divider_p_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_fix   (w_fix),
    .i_sgn   (sgn),
    .i_a     (Abus),
    .i_b     (Bbus),
    .o_bzero (w_bzero),
    .o_q     (Qbus),
    .o_r     (Rbus),
    .o_dbz   (dbz),
    .o_ovf   (ovf)
  );

endmodule

// File: tb/tb_seq_divider_p.sv
// Directed bench for seq_divider_p at WIDTH 4, 9 and 16 with hand-computed
// quotient, remainder, flag and latency expectations.
module tb_seq_divider_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        sgn_in;
  logic [15:0] a_in, b_in;
  int          wsel;
  int          checks = 0;
  int          errors = 0;

  logic        st4, st9, st16;
  logic [3:0]  q4, r4;
  logic [8:0]  q9, r9;
  logic [15:0] q16, r16;
  logic        rdy4, dn4, dz4, ov4;
  logic        rdy9, dn9, dz9, ov9;
  logic        rdy16, dn16, dz16, ov16;

  always #5 clk = ~clk;

  assign st4  = go && (wsel == 4);
  assign st9  = go && (wsel == 9);
  assign st16 = go && (wsel == 16);

  seq_divider_p #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st4), .sgn(sgn_in), .Abus(a_in[3:0]), .Bbus(b_in[3:0]),
    .Qbus(q4), .Rbus(r4), .ready(rdy4), .done(dn4), .dbz(dz4), .ovf(ov4)
  );

  seq_divider_p #(.WIDTH(9)) u_dut9 (
    .clk(clk), .rst(rst), .start(st9), .sgn(sgn_in), .Abus(a_in[8:0]), .Bbus(b_in[8:0]),
    .Qbus(q9), .Rbus(r9), .ready(rdy9), .done(dn9), .dbz(dz9), .ovf(ov9)
  );

  seq_divider_p #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(st16), .sgn(sgn_in), .Abus(a_in), .Bbus(b_in),
    .Qbus(q16), .Rbus(r16), .ready(rdy16), .done(dn16), .dbz(dz16), .ovf(ov16)
  );

  typedef struct {
    int          w;
    logic        s;
    logic [15:0] a, b, q, r;
    logic [1:0]  fl;   // {dbz, ovf}
    int          lat;
  } vec_t;

  // Issues one operation on the selected DUT and reports its result and latency in edges.
  task automatic do_op(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic [1:0] fl,
                       output int lat);
    logic d;
    @(negedge clk);
    wsel = w; sgn_in = s; a_in = a; b_in = b; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      case (w)
        4:       d = dn4;
        9:       d = dn9;
        default: d = dn16;
      endcase
      if (d) lat = n;
    end
    case (w)
      4:       begin q = 16'(q4);  r = 16'(r4);  fl = {dz4, ov4};   end
      9:       begin q = 16'(q9);  r = 16'(r9);  fl = {dz9, ov9};   end
      default: begin q = q16;      r = r16;      fl = {dz16, ov16}; end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; sgn_in = 1'b0; a_in = '0; b_in = '0; wsel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    checks++;
    if ({q9, r9} !== 18'd0) begin
      errors++; $display("FAIL reset_qr got q=%h r=%h want 0 0", q9, r9);
    end
    checks++;
    if ({rdy9, dn9, dz9, ov9} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got rdy/dn/dz/ov=%b want 1000", {rdy9, dn9, dz9, ov9});
    end
    checks++;
    if ({rdy4, rdy16, dn4, dn16} !== 4'b1100) begin
      errors++; $display("FAIL reset_others got %b want 1100", {rdy4, rdy16, dn4, dn16});
    end
  endtask

  task automatic test_vectors();
    vec_t        vecs[14];
    logic [15:0] q, r;
    logic [1:0]  fl;
    int          lat;
    vecs = '{
      '{9,  1'b0, 16'd500,  16'd7,    16'h0047, 16'd3,    2'b00, 10},
      '{9,  1'b1, 16'h019C, 16'd7,    16'h01F2, 16'h01FE, 2'b00, 10},
      '{9,  1'b1, 16'd100,  16'h01F9, 16'h01F2, 16'd2,    2'b00, 10},
      '{9,  1'b0, 16'd123,  16'd0,    16'h01FF, 16'd123,  2'b10, 1},
      '{9,  1'b1, 16'd123,  16'd0,    16'h01FF, 16'd123,  2'b10, 1},
      '{9,  1'b1, 16'h0100, 16'h01FF, 16'h0100, 16'd0,    2'b01, 10},
      '{9,  1'b0, 16'd511,  16'd1,    16'h01FF, 16'd0,    2'b00, 10},
      '{4,  1'b0, 16'd15,   16'd4,    16'h0003, 16'd3,    2'b00, 5},
      '{4,  1'b1, 16'h0008, 16'd3,    16'h000E, 16'h000E, 2'b00, 5},
      '{4,  1'b1, 16'h0008, 16'h000F, 16'h0008, 16'd0,    2'b01, 5},
      '{4,  1'b0, 16'd7,    16'd0,    16'h000F, 16'd7,    2'b10, 1},
      '{16, 1'b0, 16'd60000, 16'd123, 16'd487,  16'd99,   2'b00, 17},
      '{16, 1'b1, 16'h8AD0, 16'd7,    16'hEF43, 16'hFFFB, 2'b00, 17},
      '{16, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    2'b01, 17}
    };
    foreach (vecs[i]) begin
      do_op(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].b, q, r, fl, lat);
      checks++;
      if (lat !== vecs[i].lat) begin
        errors++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, vecs[i].lat);
      end
      checks++;
      if (q !== vecs[i].q) begin
        errors++; $display("FAIL vec%0d_q got %h want %h", i, q, vecs[i].q);
      end
      checks++;
      if (r !== vecs[i].r) begin
        errors++; $display("FAIL vec%0d_r got %h want %h", i, r, vecs[i].r);
      end
      checks++;
      if (fl !== vecs[i].fl) begin
        errors++; $display("FAIL vec%0d_flags got %b want %b", i, fl, vecs[i].fl);
      end
    end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    @(negedge clk);
    wsel = 9; sgn_in = 1'b0; a_in = 16'd500; b_in = 16'd7; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({q9, r9, dn9, dz9, ov9, rdy9} !== {18'd0, 4'b0001}) begin
      errors++;
      $display("FAIL midreset_outputs got q=%h r=%h dn/dz/ov/rdy=%b want 0 0 0001",
               q9, r9, {dn9, dz9, ov9, rdy9});
    end
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      #1 if (dn9) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL midreset_nodone got %0d done pulses want 0", dones);
    end
  endtask

  task automatic test_busy_start();
    int lat = -1;
    int dones = 0;
    @(negedge clk);
    wsel = 9; sgn_in = 1'b0; a_in = 16'd500; b_in = 16'd7; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) begin a_in = 16'd100; b_in = 16'd3; go = 1'b1; end
      if (n == 4) go = 1'b0;
      if (dn9) begin
        dones++;
        if (lat < 0) begin
          lat = n;
          checks++;
          if ({q9, r9} !== {9'd71, 9'd3}) begin
            errors++; $display("FAIL busy_result got q=%0d r=%0d want 71 3", q9, r9);
          end
        end
      end
    end
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL busy_latency got %0d want 10", lat);
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL busy_dones got %0d want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    @(negedge clk);
    wsel = 9; sgn_in = 1'b0; a_in = 16'd500; b_in = 16'd7; go = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40 && second < 0; n++) begin
      @(posedge clk);
      #1;
      if (first >= 0 && n == first + 1) go = 1'b0;
      if (dn9 && first < 0) begin
        first = n;
        checks++;
        if ({q9, r9, rdy9} !== {9'd71, 9'd3, 1'b1}) begin
          errors++; $display("FAIL b2b_first got q=%0d r=%0d rdy=%b want 71 3 1", q9, r9, rdy9);
        end
        a_in = 16'd100; b_in = 16'd3;
      end else if (dn9) begin
        second = n;
      end
    end
    go = 1'b0;
    checks++;
    if (first !== 10 || second !== 21) begin
      errors++; $display("FAIL b2b_timing got %0d,%0d want 10,21", first, second);
    end
    checks++;
    if ({q9, r9} !== {9'd33, 9'd1}) begin
      errors++; $display("FAIL b2b_second got q=%0d r=%0d want 33 1", q9, r9);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_mid_reset();
    test_busy_start();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
